// File: rtl/isa_pkg.sv
// ISA constants, ALU codes, instruction field layout and the decoded control word
// shared by the decode stage and its register file.
package isa_pkg;

    localparam int OPC_W  = 5;
    // rd starts this many bits below the instruction MSB; rs1/rs2 follow contiguously
    localparam int RD_OFS = OPC_W;

    localparam logic [OPC_W-1:0] OP_NOP = 5'b00000;
    localparam logic [OPC_W-1:0] OP_ADD = 5'b00001;
    localparam logic [OPC_W-1:0] OP_SUB = 5'b00010;
    localparam logic [OPC_W-1:0] OP_AND = 5'b00011;
    localparam logic [OPC_W-1:0] OP_OR  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_NOT = 5'b00101;
    localparam logic [OPC_W-1:0] OP_LDM = 5'b01000;
    localparam logic [OPC_W-1:0] OP_LDD = 5'b01001;
    localparam logic [OPC_W-1:0] OP_STD = 5'b01010;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_NOT   = 3'd4;
    localparam logic [2:0] ALU_PASSB = 3'd5;

    typedef enum logic {S_OP, S_IMM} state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src_imm;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal;
        logic       two_word;
        logic       use_rs1;
        logic       use_rs2;
    } ctrl_t;

    function automatic ctrl_t decode_op(input logic [OPC_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_NOP: c = '0;
            OP_ADD: begin c.alu_op = ALU_ADD; c.reg_write = 1'b1; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
            OP_SUB: begin c.alu_op = ALU_SUB; c.reg_write = 1'b1; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
            OP_AND: begin c.alu_op = ALU_AND; c.reg_write = 1'b1; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
            OP_OR:  begin c.alu_op = ALU_OR;  c.reg_write = 1'b1; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
            OP_NOT: begin c.alu_op = ALU_NOT; c.reg_write = 1'b1; c.use_rs1 = 1'b1; end
            OP_LDM: begin
                c.alu_op = ALU_PASSB; c.alu_src_imm = 1'b1; c.reg_write = 1'b1; c.two_word = 1'b1;
            end
            OP_LDD: begin
                c.alu_op = ALU_ADD; c.alu_src_imm = 1'b1; c.mem_read = 1'b1; c.reg_write = 1'b1;
                c.mem_to_reg = 1'b1; c.two_word = 1'b1; c.use_rs1 = 1'b1;
            end
            OP_STD: begin
                c.alu_op = ALU_ADD; c.alu_src_imm = 1'b1; c.mem_write = 1'b1; c.two_word = 1'b1;
                c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file with two combinational read ports and same-cycle write-back bypass.
// Optional macro ZERO_REG_EN makes R0 a constant zero that ignores writes.
module id_regfile #(
    parameter int DATA_W = 16,
    parameter int N_REGS = 8,
    localparam int AW = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [N_REGS];
    logic              wr_en;

`ifdef ZERO_REG_EN
    assign wr_en = we && (waddr != '0);
`else
    assign wr_en = we;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = (wr_en && waddr == raddr1) ? wdata : regs[raddr1];
        rdata2 = (wr_en && waddr == raddr2) ? wdata : regs[raddr2];
`ifdef ZERO_REG_EN
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
`endif
    end

endmodule

// File: rtl/id_stage_p.sv
// Instruction-decode stage: one/two-word decode, register read with bypass, load-use
// stall and a registered ID/EX bundle. Optional macro ZERO_REG_EN hard-wires R0 to zero.
module id_stage_p
    import isa_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_REGS = 8,
    parameter int INST_W = 16,
    parameter int PC_W   = 16,
    localparam int REG_AW = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [INST_W-1:0] if_inst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              id_ready,
    input  logic              flush,
    input  logic              ex_ready,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [2:0]        ex_alu_op,
    output logic              ex_alu_src_imm,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_illegal,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [PC_W-1:0]   ex_pc
);

    localparam int RD_MSB  = INST_W - 1 - RD_OFS;
    localparam int RS1_MSB = RD_MSB - REG_AW;
    localparam int RS2_MSB = RS1_MSB - REG_AW;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [INST_W-1:0] w);
        logic signed [INST_W-1:0] s;
        s = w;
        return DATA_W'(s);
    endfunction

    state_t            state, state_nxt;
    ctrl_t             in_ctrl, lat_ctrl, pend_ctrl;
    logic [REG_AW-1:0] in_rd, in_rs1, in_rs2;
    logic [REG_AW-1:0] lat_rd, lat_rs1, lat_rs2;
    logic [REG_AW-1:0] pend_rd, pend_rs1, pend_rs2;
    logic [PC_W-1:0]   lat_pc, pend_pc;
    logic [DATA_W-1:0] rd_data1, rd_data2;
    logic              issuing, hazard, advance, accept, issue, ex_rd_live;

    assign in_ctrl = decode_op(if_inst[INST_W-1 -: OPC_W]);
    assign in_rd   = if_inst[RD_MSB  -: REG_AW];
    assign in_rs1  = if_inst[RS1_MSB -: REG_AW];
    assign in_rs2  = if_inst[RS2_MSB -: REG_AW];

    // In S_IMM the instruction being issued is the latched first word, not the fetch word
    always_comb begin
        pend_ctrl = in_ctrl;
        pend_rd   = in_rd;
        pend_rs1  = in_rs1;
        pend_rs2  = in_rs2;
        pend_pc   = if_pc;
        if (state == S_IMM) begin
            pend_ctrl = lat_ctrl;
            pend_rd   = lat_rd;
            pend_rs1  = lat_rs1;
            pend_rs2  = lat_rs2;
            pend_pc   = lat_pc;
        end
    end

`ifdef ZERO_REG_EN
    assign ex_rd_live = (ex_rd != '0);
`else
    assign ex_rd_live = 1'b1;
`endif

    assign issuing  = (state == S_IMM) || !pend_ctrl.two_word;
    assign hazard   = issuing && ex_valid && ex_mem_read && ex_rd_live &&
                      ((pend_ctrl.use_rs1 && pend_rs1 == ex_rd) ||
                       (pend_ctrl.use_rs2 && pend_rs2 == ex_rd));
    assign advance  = !ex_valid || ex_ready;
    assign id_ready = rst && advance && !hazard;
    assign accept   = if_valid && id_ready && !flush;
    assign issue    = accept && issuing;

    id_regfile #(.DATA_W(DATA_W), .N_REGS(N_REGS)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (pend_rs1),
        .raddr2 (pend_rs2),
        .rdata1 (rd_data1),
        .rdata2 (rd_data2)
    );

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_OP;
        end else if (accept) begin
            case (state)
                S_OP:  if (in_ctrl.two_word) state_nxt = S_IMM;
                S_IMM: state_nxt = S_OP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_OP;
            lat_ctrl <= '0;
            lat_rd   <= '0;
            lat_rs1  <= '0;
            lat_rs2  <= '0;
            lat_pc   <= '0;
        end else begin
            state <= state_nxt;
            if (accept && state == S_OP && in_ctrl.two_word) begin
                lat_ctrl <= in_ctrl;
                lat_rd   <= in_rd;
                lat_rs1  <= in_rs1;
                lat_rs2  <= in_rs2;
                lat_pc   <= if_pc;
            end
        end
    end

    // ID/EX boundary: flush kills, a stalled execute holds, otherwise load on issue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid       <= 1'b0;
            ex_alu_op      <= '0;
            ex_alu_src_imm <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
            ex_illegal     <= 1'b0;
            ex_rd          <= '0;
            ex_rs1         <= '0;
            ex_rs2         <= '0;
            ex_rdata1      <= '0;
            ex_rdata2      <= '0;
            ex_imm         <= '0;
            ex_pc          <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (advance) begin
            ex_valid <= issue;
            if (issue) begin
                ex_alu_op      <= pend_ctrl.alu_op;
                ex_alu_src_imm <= pend_ctrl.alu_src_imm;
                ex_mem_read    <= pend_ctrl.mem_read;
                ex_mem_write   <= pend_ctrl.mem_write;
                ex_reg_write   <= pend_ctrl.reg_write;
                ex_mem_to_reg  <= pend_ctrl.mem_to_reg;
                ex_illegal     <= pend_ctrl.illegal;
                ex_rd          <= pend_rd;
                ex_rs1         <= pend_rs1;
                ex_rs2         <= pend_rs2;
                ex_rdata1      <= rd_data1;
                ex_rdata2      <= rd_data2;
                ex_imm         <= (state == S_IMM) ? sext_imm(if_inst) : '0;
                ex_pc          <= pend_pc;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_p.sv
// Scoreboard bench for id_stage_p (DATA_W = 32 so immediate sign extension is visible):
// a cycle-level reference model queues expected bundles, a monitor compares them.
module tb_id_stage_p;

    localparam int DW = 32;
    localparam int IW = 16;
    localparam int PW = 16;
    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_valid;
    logic [IW-1:0] if_inst;
    logic [PW-1:0] if_pc;
    logic          id_ready;
    logic          flush;
    logic          ex_ready;
    logic          wb_we;
    logic [2:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          ex_valid;
    logic [2:0]    ex_alu_op;
    logic          ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_illegal;
    logic [2:0]    ex_rd, ex_rs1, ex_rs2;
    logic [DW-1:0] ex_rdata1, ex_rdata2, ex_imm;
    logic [PW-1:0] ex_pc;

    id_stage_p #(.DATA_W(DW), .N_REGS(NR), .INST_W(IW), .PC_W(PW)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data(wb_data), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_alu_src_imm(ex_alu_src_imm), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_illegal(ex_illegal),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rdata1(ex_rdata1),
        .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc(ex_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    alu_op;
        logic          src_imm, mr, mw, rw, m2r, ill;
        logic [2:0]    rd, rs1, rs2;
        logic [DW-1:0] d1, d2, imm;
        logic [PW-1:0] pc;
    } bund_t;

    typedef struct packed {
        logic [2:0] alu;
        logic       imm, mr, mw, rw, m2r, ill, two, u1, u2;
    } dec_t;

    bund_t         sb[$];
    int            tests = 0;
    int            fails = 0;

    logic [DW-1:0] mregs [NR];
    bit            m_imm_mode;
    logic [IW-1:0] m_first;
    logic [PW-1:0] m_first_pc;
    bit            m_exv, m_ex_mr;
    logic [2:0]    m_ex_rd;
    logic [PW-1:0] pc_ctr;

    wire [130:0] all_ex = {ex_valid, ex_alu_op, ex_alu_src_imm, ex_mem_read, ex_mem_write,
                           ex_reg_write, ex_mem_to_reg, ex_illegal, ex_rd, ex_rs1, ex_rs2,
                           ex_rdata1, ex_rdata2, ex_imm, ex_pc};

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction semantics straight from the opcode table
    function automatic dec_t ref_dec(input logic [4:0] op);
        dec_t d;
        d = '0;
        if (op >= 5'd1 && op <= 5'd5) begin
            d.alu = 3'(op - 5'd1); d.rw = 1; d.u1 = 1; d.u2 = (op != 5'd5);
        end else if (op == 5'd8) begin
            d.alu = 3'd5; d.imm = 1; d.rw = 1; d.two = 1;
        end else if (op == 5'd9) begin
            d.imm = 1; d.mr = 1; d.rw = 1; d.m2r = 1; d.two = 1; d.u1 = 1;
        end else if (op == 5'd10) begin
            d.imm = 1; d.mw = 1; d.two = 1; d.u1 = 1; d.u2 = 1;
        end else if (op != 5'd0) begin
            d.ill = 1;
        end
        return d;
    endfunction

    function automatic logic [DW-1:0] rdreg(input logic [2:0] a);
`ifdef ZERO_REG_EN
        if (a == 3'd0) return '0;
`endif
        if (wb_we && wb_addr == a) return wb_data;
        return mregs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        m_imm_mode = 0; m_first = '0; m_first_pc = '0;
        m_exv = 0; m_ex_mr = 0; m_ex_rd = '0;
        sb.delete();
    endtask

    // One clock: drive at posedge+1, check handshake, update model just after negedge
    task automatic cycle(input bit v, input logic [IW-1:0] w, input bit fl, input bit rdy,
                         input bit we, input logic [2:0] wa, input logic [DW-1:0] wd);
        logic [IW-1:0] pw;
        dec_t d;
        bit issuing, hz, adv, er, acc, live;
        bund_t b;
        if_valid = v; if_inst = w; if_pc = pc_ctr; flush = fl; ex_ready = rdy;
        wb_we = we; wb_addr = wa; wb_data = wd;
        #1;
        pw = m_imm_mode ? m_first : w;
        d = ref_dec(pw[15:11]);
        issuing = m_imm_mode || !d.two;
        live = 1;
`ifdef ZERO_REG_EN
        live = (m_ex_rd != 3'd0);
`endif
        hz = issuing && m_exv && m_ex_mr && live &&
             ((d.u1 && pw[7:5] == m_ex_rd) || (d.u2 && pw[4:2] == m_ex_rd));
        adv = !m_exv || rdy;
        er  = adv && !hz;
        check("id_ready", id_ready, er);
        check("ex_valid", ex_valid, m_exv);
        acc = v && er && !fl;
        b.alu_op = d.alu; b.src_imm = d.imm; b.mr = d.mr; b.mw = d.mw; b.rw = d.rw;
        b.m2r = d.m2r; b.ill = d.ill;
        b.rd = pw[10:8]; b.rs1 = pw[7:5]; b.rs2 = pw[4:2];
        b.d1 = rdreg(pw[7:5]); b.d2 = rdreg(pw[4:2]);
        b.imm = m_imm_mode ? {{(DW-IW){w[IW-1]}}, w} : '0;
        b.pc = m_imm_mode ? m_first_pc : pc_ctr;
        @(negedge clk); #1;
        if (fl) begin
            if (m_exv && !rdy) void'(sb.pop_back());
            m_exv = 0; m_imm_mode = 0;
        end else begin
            if (adv) begin
                m_exv = acc && issuing;
                if (acc && issuing) begin
                    sb.push_back(b); m_ex_mr = d.mr; m_ex_rd = pw[10:8];
                end
            end
            if (acc) begin
                if (!m_imm_mode && d.two) begin
                    m_imm_mode = 1; m_first = w; m_first_pc = pc_ctr;
                end else begin
                    m_imm_mode = 0;
                end
            end
        end
        if (acc) pc_ctr = pc_ctr + 1'b1;
`ifdef ZERO_REG_EN
        if (we && wa != 3'd0) mregs[wa] = wd;
`else
        if (we) mregs[wa] = wd;
`endif
        @(posedge clk); #1;
    endtask

    task automatic mid_reset();
        rst = 1'b0;
        #1;
        check("reset_outputs", all_ex, '0);
        check("reset_id_ready", id_ready, 1'b0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("ready_after_reset", id_ready, 1'b1);
    endtask

    // Monitor: every presented bundle must match the head of the scoreboard
    initial begin : monitor
        bund_t a;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && ex_valid === 1'b1) begin
                a = {ex_alu_op, ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write,
                     ex_mem_to_reg, ex_illegal, ex_rd, ex_rs1, ex_rs2, ex_rdata1, ex_rdata2,
                     ex_imm, ex_pc};
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL bundle: unexpected bundle %0h with empty scoreboard at %0t", a, $time);
                end else begin
                    check("bundle", a, sb[0]);
                    if (ex_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin : stim
        logic [4:0] ops [12];
        logic [4:0] op;
        rst = 1'b0; if_valid = 0; if_inst = '0; if_pc = '0; flush = 0; ex_ready = 0;
        wb_we = 0; wb_addr = '0; wb_data = '0; pc_ctr = 16'h0100;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", all_ex, '0);
        check("reset_id_ready", id_ready, 1'b0);
        rst = 1'b1;
        #1;
        check("ready_after_reset", id_ready, 1'b1);
        check("valid_after_reset", ex_valid, 1'b0);

        // read after write, then same-cycle bypass
        cycle(0, 16'h0000, 0, 1, 1, 3'd3, 32'h1234);
        cycle(1, 16'h096C, 0, 1, 0, 3'd0, 32'h0);
        cycle(1, 16'h1140, 0, 1, 1, 3'd2, 32'hBEEF);
        // two-word LDM with a negative immediate
        cycle(1, 16'h4400, 0, 1, 0, 3'd0, 32'h0);
        cycle(1, 16'hFF80, 0, 1, 0, 3'd0, 32'h0);
        // load-use stall, including a held bundle under ex_ready = 0
        cycle(1, 16'h4D20, 0, 1, 0, 3'd0, 32'h0);
        cycle(1, 16'h0004, 0, 1, 0, 3'd0, 32'h0);
        cycle(1, 16'h0EA4, 0, 0, 0, 3'd0, 32'h0);
        cycle(1, 16'h0EA4, 0, 0, 0, 3'd0, 32'h0);
        cycle(1, 16'h0EA4, 0, 1, 0, 3'd0, 32'h0);
        cycle(1, 16'h0EA4, 0, 1, 0, 3'd0, 32'h0);
        // flush while holding a first word
        cycle(1, 16'h4400, 0, 1, 0, 3'd0, 32'h0);
        cycle(1, 16'hFF80, 1, 1, 0, 3'd0, 32'h0);
        cycle(1, 16'h096C, 0, 1, 0, 3'd0, 32'h0);
        // reset in the middle of a two-word instruction
        cycle(1, 16'h4400, 0, 1, 0, 3'd0, 32'h0);
        mid_reset();
        cycle(1, 16'h096C, 0, 1, 0, 3'd0, 32'h0);
        cycle(1, 16'hF800, 0, 1, 0, 3'd0, 32'h0);

        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd9, 5'd9, 5'd0};
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) mid_reset();
            op = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(11, 31));
            cycle($urandom_range(0, 9) < 8, {op, 11'($urandom)}, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                  3'($urandom_range(0, 7)), 32'($urandom));
        end
        repeat (4) cycle(0, 16'h0000, 0, 1, 0, 3'd0, 32'h0);
        check("scoreboard_drained", 160'(sb.size()), 160'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
